// File: rtl/mycpu_pkg.sv
// mycpu_pkg: load type codes and shared defaults for the MEM stage.
package mycpu_pkg;
  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_H  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    LD_D  = 3'd5
  } ld_type_e;
  localparam int DATA_W_32      = 32;
  localparam int DATA_W_64      = 64;
  localparam int MAX_ORPHAN_DEF = 3;
endpackage

// File: rtl/mem_resp_stage_load_align.sv
// load_align: selects the addressed lane of the raw load data and extends it to DATA_W.
module load_align
  import mycpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]           raw_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  logic [2:0]                  ld_type_i,
  output logic [DATA_W-1:0]           res_o
);
  logic [DATA_W-1:0] lane;
  assign lane = raw_i >> {off_i, 3'b000};
  always_comb
    res_o = ld_type_i == LD_B  ? {{(DATA_W-8){lane[7]}}, lane[7:0]} :
            ld_type_i == LD_H  ? {{(DATA_W-16){lane[15]}}, lane[15:0]} :
            ld_type_i == LD_BU ? DATA_W'(lane[7:0]) :
            ld_type_i == LD_HU ? DATA_W'(lane[15:0]) :
            ld_type_i == LD_W  ? DATA_W'(lane[31:0]) : raw_i;
endmodule

// File: rtl/mem_resp_stage.sv
// mem_resp_stage: MEM stage holding one instruction while its split-transaction data response returns,
// with a one-entry response buffer for WB backpressure and orphan-response discard after flushes.
module mem_resp_stage
  import mycpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SIDE_W     = 82,
  parameter int MAX_ORPHAN = MAX_ORPHAN_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [4:0]        es_dest,
  input  logic              es_gr_we,
  input  logic              es_res_from_mem,
  input  logic [2:0]        es_ld_type,
  input  logic              es_mem_req,
  input  logic              es_ex,
  input  logic              es_ertn,
  input  logic [SIDE_W-1:0] es_side_bus,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  input  logic              wb_flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic [DATA_W-1:0] ms_result,
  output logic [4:0]        ms_dest,
  output logic              ms_gr_we,
  output logic              ms_ex,
  output logic              ms_ertn,
  output logic [SIDE_W-1:0] ms_side_bus,
  output logic [4:0]        ms_fwd_dest,
  output logic [DATA_W-1:0] ms_fwd_result,
  output logic              ms_fwd_stall,
  output logic              ms_ex_ertn
);
  localparam int OW = $clog2(DATA_W/8);
  localparam int CW = $clog2(MAX_ORPHAN+1);
  logic              ms_valid_q, ms_valid_d, ms_wait_q, ms_wait_d, buf_valid_q, buf_valid_d;
  logic [CW-1:0]     orphan_q, orphan_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] alu_q;
  logic [4:0]        dest_q;
  logic              gr_we_q, rfm_q, ex_q, ertn_q;
  logic [2:0]        ldt_q;
  logic [SIDE_W-1:0] side_q;
  logic              accept, ready_go, dok_orphan, dok_cur, leave, capture, orphan_ovf;
  logic [CW+1:0]     orphan_sum;
  logic [DATA_W-1:0] raw, aligned;
  // Responses are in order, so any outstanding orphan owns the strobe before the live instruction.
  assign dok_orphan = data_sram_data_ok & (orphan_q != '0);
  assign dok_cur    = data_sram_data_ok & (orphan_q == '0) & ms_valid_q & ms_wait_q;
  assign ready_go   = !ms_wait_q | buf_valid_q | (data_sram_data_ok & (orphan_q == '0));
  assign ms_allowin = !ms_valid_q | (ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ready_go;
  assign leave      = ms_to_ws_valid & ws_allowin;
  assign accept     = es_to_ms_valid & ms_allowin & !wb_flush;
  assign capture    = dok_cur & !ws_allowin;
  assign orphan_sum = (CW+2)'(orphan_q)
                    + (CW+2)'(wb_flush & ms_valid_q & ms_wait_q & !dok_cur)
                    + (CW+2)'(wb_flush & es_to_ms_valid & es_mem_req)
                    - (CW+2)'(dok_orphan);
  assign orphan_ovf = orphan_sum > (CW+2)'(MAX_ORPHAN);
  always_comb begin
    ms_valid_d  = (reset | wb_flush) ? 1'b0 : ms_allowin ? es_to_ms_valid : ms_valid_q;
    ms_wait_d   = (reset | wb_flush) ? 1'b0 : accept ? es_mem_req : dok_cur ? 1'b0 : ms_wait_q;
    buf_valid_d = (reset | wb_flush | leave) ? 1'b0 : capture ? 1'b1 : buf_valid_q;
    buf_d       = capture ? data_sram_rdata : buf_q;
    orphan_d    = reset ? '0 : orphan_ovf ? CW'(MAX_ORPHAN) : orphan_sum[CW-1:0];
  end
  always_ff @(posedge clk) begin
    ms_valid_q  <= ms_valid_d;
    ms_wait_q   <= ms_wait_d;
    buf_valid_q <= buf_valid_d;
    buf_q       <= buf_d;
    orphan_q    <= orphan_d;
  end
  always_ff @(posedge clk)
    if (accept) begin
      pc_q    <= es_pc;
      alu_q   <= es_alu_result;
      dest_q  <= es_dest;
      gr_we_q <= es_gr_we;
      rfm_q   <= es_res_from_mem;
      ldt_q   <= es_ld_type;
      ex_q    <= es_ex;
      ertn_q  <= es_ertn;
      side_q  <= es_side_bus;
    end
  assign raw = buf_valid_q ? buf_q : data_sram_rdata;
  load_align #(.DATA_W(DATA_W)) u_align (
    .raw_i    (raw),
    .off_i    (alu_q[OW-1:0]),
    .ld_type_i(ldt_q),
    .res_o    (aligned)
  );
  assign ms_pc         = pc_q;
  assign ms_result     = rfm_q ? aligned : alu_q;
  assign ms_dest       = dest_q;
  assign ms_gr_we      = gr_we_q;
  assign ms_ex         = ex_q;
  assign ms_ertn       = ertn_q;
  assign ms_side_bus   = side_q;
  assign ms_fwd_dest   = (ms_valid_q & gr_we_q) ? dest_q : 5'd0;
  assign ms_fwd_result = ms_result;
  assign ms_fwd_stall  = ms_valid_q & rfm_q & ms_wait_q & !dok_cur;
  assign ms_ex_ertn    = ms_valid_q & (ex_q | ertn_q);
  // EX is responsible for never over-committing orphan slots; saturation only guards the counter.
  assert property (@(posedge clk) disable iff (reset) !orphan_ovf);
  assert property (@(posedge clk) DATA_W == DATA_W_32 || DATA_W == DATA_W_64);
endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage: random and directed stimulus against a request-queue model of the MEM stage.
module tb_mem_resp_stage;
  localparam int SW = 82;
  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   alu;
    logic [4:0]    dest;
    logic          gr_we;
    logic          rfm;
    logic [2:0]    ldt;
    logic          ex;
    logic          ertn;
    logic          req;
    logic [SW-1:0] side;
  } ins_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, w_reset;
  logic es_to_ms_valid, es_gr_we, es_res_from_mem, es_mem_req, es_ex, es_ertn;
  logic [31:0] es_pc, es_alu_result, rdata;
  logic [4:0] es_dest;
  logic [2:0] es_ld_type;
  logic [SW-1:0] es_side_bus;
  logic data_ok, wb_flush, ws_allowin;
  logic ms_allowin, ms_to_ws_valid, ms_gr_we, ms_ex, ms_ertn, ms_fwd_stall, ms_ex_ertn;
  logic [31:0] ms_pc, ms_result, ms_fwd_result;
  logic [4:0] ms_dest, ms_fwd_dest;
  logic [SW-1:0] ms_side_bus;
  logic w_valid, w_req, w_rfm, w_dok, w_fl, w_ws;
  logic [63:0] w_alu, w_rd, w_result, w_fwd_result;
  logic [2:0] w_ldt;
  logic w_allowin, w_to_ws_valid, w_gr_we, w_ex, w_ertn, w_stall, w_ex_ertn;
  logic [31:0] w_pc;
  logic [4:0] w_dest, w_fwd_dest;
  logic [SW-1:0] w_side;
  mem_resp_stage #(.DATA_W(32), .SIDE_W(SW), .MAX_ORPHAN(3)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_res_from_mem(es_res_from_mem), .es_ld_type(es_ld_type), .es_mem_req(es_mem_req),
    .es_ex(es_ex), .es_ertn(es_ertn), .es_side_bus(es_side_bus), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .wb_flush(wb_flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc), .ms_result(ms_result), .ms_dest(ms_dest),
    .ms_gr_we(ms_gr_we), .ms_ex(ms_ex), .ms_ertn(ms_ertn), .ms_side_bus(ms_side_bus),
    .ms_fwd_dest(ms_fwd_dest), .ms_fwd_result(ms_fwd_result), .ms_fwd_stall(ms_fwd_stall),
    .ms_ex_ertn(ms_ex_ertn)
  );
  mem_resp_stage #(.DATA_W(64), .SIDE_W(SW), .MAX_ORPHAN(3)) dut64 (
    .clk(clk), .reset(w_reset), .es_to_ms_valid(w_valid), .ms_allowin(w_allowin),
    .es_pc(es_pc), .es_alu_result(w_alu), .es_dest(es_dest), .es_gr_we(es_gr_we),
    .es_res_from_mem(w_rfm), .es_ld_type(w_ldt), .es_mem_req(w_valid & w_req),
    .es_ex(es_ex), .es_ertn(es_ertn), .es_side_bus(es_side_bus), .data_sram_data_ok(w_dok),
    .data_sram_rdata(w_rd), .wb_flush(w_fl), .ws_allowin(w_ws),
    .ms_to_ws_valid(w_to_ws_valid), .ms_pc(w_pc), .ms_result(w_result), .ms_dest(w_dest),
    .ms_gr_we(w_gr_we), .ms_ex(w_ex), .ms_ertn(w_ertn), .ms_side_bus(w_side),
    .ms_fwd_dest(w_fwd_dest), .ms_fwd_result(w_fwd_result), .ms_fwd_stall(w_stall),
    .ms_ex_ertn(w_ex_ertn)
  );
  int n_cmp = 0, n_bad = 0;
  // Model: MS slot, EX slot, and the in-order list of owed responses (1 = killed by a flush).
  bit occ, got, ex_has;
  ins_t cur, exi;
  logic [31:0] gdata;
  bit q[$];
  bit dok, ws, fl, e_valid, e_allow, dok_cur;
  logic [31:0] rd;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] m_align(input logic [31:0] raw, input logic [31:0] addr, input logic [2:0] t);
    logic [31:0] v;
    v = raw >> (8 * (addr % 4));
    case (t)
      3'd1: v = (v & 32'hFF) >= 128 ? (v & 32'hFF) - 32'd256 : v & 32'hFF;
      3'd2: v = (v & 32'hFFFF) >= 32768 ? (v & 32'hFFFF) - 32'd65536 : v & 32'hFFFF;
      3'd3: v = v & 32'hFF;
      3'd4: v = v & 32'hFFFF;
      default: v = raw;
    endcase
    return v;
  endfunction
  function automatic ins_t mk(input logic [31:0] alu, input logic [2:0] ldt, input bit req, input bit rfm, input bit we);
    ins_t i;
    i.pc = $urandom; i.alu = alu; i.dest = 5'($urandom); i.gr_we = we; i.rfm = rfm; i.ldt = ldt;
    i.ex = 1'b0; i.ertn = 1'b0; i.req = req; i.side = SW'({$urandom, $urandom, $urandom});
    return i;
  endfunction
  function automatic ins_t rand_ins();
    ins_t i;
    int k = $urandom_range(0, 9);
    logic [2:0] t = 3'($urandom_range(0, 4));
    logic [31:0] a = $urandom;
    if (t == 3'd2 || t == 3'd4) a[0] = 1'b0;
    if (t == 3'd0) a[1:0] = 2'b00;
    i = k < 4 ? mk(a, t, 1, 1, 1) : k < 6 ? mk(a, t, 1, 0, 0) : mk(a, t, 0, 0, 1'($urandom));
    i.ex = k == 6;
    i.ertn = k == 7;
    return i;
  endfunction
  task automatic new_ex(input ins_t i);
    exi = i;
    ex_has = 1;
    if (i.req) q.push_back(1'b0);
  endtask
  task automatic settle();
    bit owe, ready;
    es_to_ms_valid = ex_has; es_pc = exi.pc; es_alu_result = exi.alu; es_dest = exi.dest;
    es_gr_we = exi.gr_we; es_res_from_mem = exi.rfm; es_ld_type = exi.ldt; es_ex = exi.ex;
    es_ertn = exi.ertn; es_side_bus = exi.side; es_mem_req = ex_has & exi.req;
    data_ok = dok; rdata = rd; wb_flush = fl; ws_allowin = ws;
    @(negedge clk);
    dok_cur = dok && q.size() > 0 && !q[0];
    owe = occ && cur.req && !got;
    ready = !owe || dok_cur;
    e_valid = occ && ready;
    e_allow = !occ || (ready && ws);
    chk("to_ws_valid", ms_to_ws_valid, e_valid);
    chk("allowin", ms_allowin, e_allow);
    chk("fwd_stall", ms_fwd_stall, occ && cur.rfm && owe && !dok_cur);
    chk("ex_ertn", ms_ex_ertn, occ && (cur.ex || cur.ertn));
    chk("fwd_dest", ms_fwd_dest, (occ && cur.gr_we) ? cur.dest : 5'd0);
    if (occ) begin
      chk("pc", ms_pc, cur.pc);
      chk("dest", ms_dest, cur.dest);
      chk("gr_we", ms_gr_we, cur.gr_we);
      chk("ex", ms_ex, cur.ex);
      chk("ertn", ms_ertn, cur.ertn);
      chk("side", ms_side_bus, cur.side);
    end
    if (e_valid) begin
      chk("result", ms_result, cur.rfm ? m_align(got ? gdata : rd, cur.alu, cur.ldt) : cur.alu);
      chk("fwd_result", ms_fwd_result, cur.rfm ? m_align(got ? gdata : rd, cur.alu, cur.ldt) : cur.alu);
    end
  endtask
  task automatic advance();
    bit acc, leave;
    acc = ex_has && e_allow;
    leave = e_valid && ws;
    if (dok && q.size() > 0) begin
      if (!q[0]) begin got = 1; gdata = rd; end
      void'(q.pop_front());
    end
    if (fl) begin
      foreach (q[i]) q[i] = 1'b1;
      occ = 0; got = 0; ex_has = 0;
    end else if (acc) begin
      occ = 1; cur = exi; got = 0; ex_has = 0;
    end else if (leave) occ = 0;
    @(posedge clk);
    #1;
  endtask
  task automatic rand_inputs();
    if (!ex_has && $urandom_range(0, 9) < 7) new_ex(rand_ins());
    dok = 0;
    if (q.size() > 0 && (q[0] || (occ && cur.req && !got))) dok = 1'($urandom_range(0, 1));
    rd = $urandom;
    ws = $urandom_range(0, 9) < 6;
    fl = $urandom_range(0, 24) == 0 && q.size() <= 3;
  endtask
  initial begin
    reset = 1; w_reset = 1; ex_has = 0; occ = 0; got = 0; dok = 0; fl = 0; ws = 1; rd = 0;
    exi = mk(0, 0, 0, 0, 0); cur = exi;
    w_valid = 0; w_req = 0; w_rfm = 0; w_dok = 0; w_fl = 0; w_ws = 1; w_alu = 0; w_rd = 0; w_ldt = 0;
    data_ok = 0; wb_flush = 0; es_to_ms_valid = 0; es_mem_req = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("model_ldb", m_align(32'h80FF_1234, 32'h1003, 3'd1), 32'hFFFF_FF80);
    chk("model_lhu", m_align(32'hBEEF_0001, 32'h2002, 3'd4), 32'h0000_BEEF);
    settle();
    chk("reset_valid", ms_to_ws_valid, 1'b0);
    chk("reset_allowin", ms_allowin, 1'b1);
    chk("reset_stall", ms_fwd_stall, 1'b0);
    chk("reset_ex_ertn", ms_ex_ertn, 1'b0);
    advance();
    new_ex(mk(32'h1003, 3'd1, 1, 1, 1));
    settle(); chk("t1_allowin", ms_allowin, 1'b1); advance();
    repeat (2) begin settle(); chk("t1_stall", ms_fwd_stall, 1'b1); chk("t1_wait", ms_to_ws_valid, 1'b0); advance(); end
    dok = 1; rd = 32'h80FF_1234;
    settle(); chk("t1_valid", ms_to_ws_valid, 1'b1); chk("t1_result", ms_result, 32'hFFFF_FF80);
    chk("t1_stall_off", ms_fwd_stall, 1'b0); advance();
    dok = 0;
    new_ex(mk(32'h2002, 3'd4, 1, 1, 1));
    settle(); advance();
    ws = 0; dok = 1; rd = 32'hBEEF_0001;
    settle(); chk("t2_valid", ms_to_ws_valid, 1'b1); advance();
    dok = 0; rd = 32'h1111_2222;
    repeat (2) begin settle(); chk("t2_held", ms_result, 32'h0000_BEEF); advance(); end
    ws = 1;
    settle(); chk("t2_handoff", ms_result, 32'h0000_BEEF); advance();
    settle(); chk("t2_single", ms_to_ws_valid, 1'b0); advance();
    new_ex(mk(32'h3000, 3'd0, 1, 1, 1));
    settle(); advance();
    fl = 1; settle(); advance(); fl = 0;
    new_ex(mk(32'h4000, 3'd0, 1, 1, 1));
    dok = 1; rd = 32'h0000_DEAD;
    settle(); advance();
    dok = 0;
    settle(); chk("t3_dropped", ms_fwd_stall, 1'b1); advance();
    dok = 1; rd = 32'h0000_1234;
    settle(); chk("t3_result", ms_result, 32'h0000_1234); chk("t3_valid", ms_to_ws_valid, 1'b1); advance();
    dok = 0;
    new_ex(mk(32'h5000, 3'd0, 1, 1, 1));
    settle(); advance();
    new_ex(mk(32'h6000, 3'd0, 1, 1, 1));
    settle(); advance();
    fl = 1; settle(); advance(); fl = 0;
    new_ex(mk(32'h7001, 3'd3, 1, 1, 1));
    dok = 1; rd = 32'h0000_DEAD;
    settle(); advance();
    rd = 32'h0000_BEEF;
    settle(); chk("t4_second_drop", ms_fwd_stall, 1'b1); advance();
    rd = 32'h0000_AB00;
    settle(); chk("t4_result", ms_result, 32'h0000_00AB); chk("t4_valid", ms_to_ws_valid, 1'b1); advance();
    dok = 0;
    new_ex(mk(32'h8000, 3'd0, 1, 0, 0));
    settle(); advance();
    new_ex(mk(32'h0000_0055, 3'd0, 0, 0, 1));
    settle(); chk("t5_block", ms_allowin, 1'b0); advance();
    dok = 1; rd = $urandom;
    settle(); chk("t5_store_out", ms_to_ws_valid, 1'b1); chk("t5_allowin", ms_allowin, 1'b1); advance();
    dok = 0;
    settle(); chk("t5_add_valid", ms_to_ws_valid, 1'b1); chk("t5_add_result", ms_result, 32'h55); advance();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      settle();
      advance();
    end
    reset = 1; es_ex = 0; es_ertn = 0; es_gr_we = 1; es_dest = 5'd3; es_pc = 32'h1C00_0000;
    @(posedge clk); #1 w_reset = 0;
    w_valid = 1; w_req = 1; w_rfm = 1; w_alu = 64'h1004; w_ldt = 3'd0;
    @(negedge clk); chk("w_allowin", w_allowin, 1'b1);
    @(posedge clk); #1 w_valid = 0;
    @(negedge clk); chk("w_stall", w_stall, 1'b1); chk("w_wait", w_to_ws_valid, 1'b0);
    @(posedge clk); #1 w_dok = 1; w_rd = 64'h8000_0001_0000_0000;
    @(negedge clk); chk("w_ldw_valid", w_to_ws_valid, 1'b1); chk("w_ldw", w_result, 64'h0000_0000_8000_0001);
    chk("w_fwd_dest", w_fwd_dest, 5'd3); chk("w_pc", w_pc, 32'h1C00_0000);
    @(posedge clk); #1 w_dok = 0; w_valid = 1; w_alu = 64'h2000; w_ldt = 3'd5;
    @(posedge clk); #1 w_valid = 0; w_dok = 1; w_rd = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); chk("w_ldd", w_result, 64'h0123_4567_89AB_CDEF);
    @(posedge clk); #1 w_dok = 0; w_valid = 1; w_alu = 64'h3007; w_ldt = 3'd1;
    @(posedge clk); #1 w_valid = 0; w_dok = 1; w_rd = 64'h80FF_0000_0000_0000;
    @(negedge clk); chk("w_ldb", w_fwd_result, 64'hFFFF_FFFF_FFFF_FF80);
    @(posedge clk); #1 w_dok = 0; w_valid = 1; w_alu = 64'h4000; w_ldt = 3'd0;
    @(posedge clk); #1 w_valid = 0; w_fl = 1;
    @(posedge clk); #1 w_fl = 0; w_valid = 1; w_alu = 64'h5000;
    @(posedge clk); #1 w_valid = 0;
    @(negedge clk); chk("w_mid_wait", w_stall, 1'b1);
    @(posedge clk); #1 w_reset = 1;
    @(posedge clk); #1 w_reset = 0;
    @(negedge clk); chk("w_rst_valid", w_to_ws_valid, 1'b0); chk("w_rst_stall", w_stall, 1'b0);
    chk("w_rst_allowin", w_allowin, 1'b1); chk("w_rst_ex_ertn", w_ex_ertn, 1'b0);
    w_valid = 1; w_alu = 64'h6004; w_ldt = 3'd4;
    @(posedge clk); #1 w_valid = 0; w_dok = 1; w_rd = 64'h0000_CAFE_0000_0000;
    @(negedge clk); chk("w_orphan_clear", w_to_ws_valid, 1'b1); chk("w_lhu", w_result, 64'h0000_0000_0000_CAFE);
    @(posedge clk); #1 w_dok = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
